// File: rtl/port_req_ctrl.sv
// port_req_ctrl: store-and-forward packet buffer that requests the shared arbiter and
// streams the buffered packet out once granted.
module port_req_ctrl #(
    parameter int PORTNUM    = 16,
    parameter int PORT_ID    = 0,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 64
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_wr_vld,
    input  logic                  i_wr_sop,
    input  logic                  i_wr_eop,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    output logic                  o_wr_ready,
    output logic                  o_req,
    input  logic                  i_port_ready,
    input  logic                  i_resp,
    input  logic                  i_nresp,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_data_vld,
    output logic                  o_eop,
    output logic                  o_trunc,
    output logic [7:0]            o_lost_cnt
);
    localparam int AW = $clog2(DEPTH);
    typedef enum logic [1:0] {IDLE, LOAD, REQ, SEND} state_t;
    state_t state, next;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW:0] wcnt, rcnt;
    logic [AW-1:0] waddr;
    logic we, drop, restart, trunc_seen, full;
    logic unused;
    assign unused = i_port_ready ^ (PORT_ID < PORTNUM);
    assign full = wcnt == (AW+1)'(DEPTH);
    assign o_wr_ready = i_rst_n && (state == IDLE || state == LOAD);
    assign o_req = i_rst_n && state == REQ;
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) state <= IDLE;
        else state <= next;
    end
    always_comb begin
        next = state;
        we = 1'b0;
        drop = 1'b0;
        restart = 1'b0;
        waddr = wcnt[AW-1:0];
        case (state)
            IDLE: if (i_wr_vld && i_wr_sop) begin
                we = 1'b1;
                restart = 1'b1;
                waddr = '0;
                next = i_wr_eop ? REQ : LOAD;
            end
            LOAD: if (i_wr_vld) begin
                restart = i_wr_sop;
                drop = !i_wr_sop && full;
                we = !drop;
                waddr = i_wr_sop ? '0 : wcnt[AW-1:0];
                next = i_wr_eop ? REQ : LOAD;
            end
            REQ: next = i_resp ? SEND : REQ;
            SEND: next = (rcnt == wcnt) ? IDLE : SEND;
            default: next = IDLE;
        endcase
    end
    always_ff @(posedge i_clk) begin
        if (we) mem[waddr] <= i_wr_data;
    end
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            wcnt <= '0;
            rcnt <= '0;
            trunc_seen <= 1'b0;
            o_data <= '0;
            o_data_vld <= 1'b0;
            o_eop <= 1'b0;
            o_trunc <= 1'b0;
            o_lost_cnt <= '0;
        end else begin
            o_trunc <= 1'b0;
            if (restart) begin
                wcnt <= (AW+1)'(1);
                trunc_seen <= 1'b0;
            end else if (we) begin
                wcnt <= wcnt + 1'b1;
            end
            // overflow words are drained; flag only the first one of the packet
            if (drop) begin
                trunc_seen <= 1'b1;
                o_trunc <= !trunc_seen;
            end
            if (state == REQ) begin
                if (i_resp) begin
                    o_data <= mem[0];
                    o_data_vld <= 1'b1;
                    o_eop <= wcnt == (AW+1)'(1);
                    rcnt <= (AW+1)'(1);
                end else if (i_nresp && o_lost_cnt != 8'hFF) begin
                    o_lost_cnt <= o_lost_cnt + 1'b1;
                end
            end else if (state == SEND) begin
                if (rcnt == wcnt) begin
                    o_data_vld <= 1'b0;
                    o_eop <= 1'b0;
                    wcnt <= '0;
                    rcnt <= '0;
                end else begin
                    o_data <= mem[rcnt[AW-1:0]];
                    o_eop <= rcnt == wcnt - 1'b1;
                    rcnt <= rcnt + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_port_req_ctrl.sv
// tb_port_req_ctrl: directed checks of two requester instances (PORT_ID 0 and 3, DEPTH 8)
// with the arbiter's resp/nresp pulses driven by hand.
module tb_port_req_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [1:0] wr_vld = '0, wr_sop = '0, wr_eop = '0, resp = '0, nresp = '0;
    logic [1:0] wr_ready, req, data_vld, eop, trunc;
    logic [31:0] wr_data [2];
    logic [31:0] data [2];
    logic [7:0] lost [2];
    int total = 0, pass = 0;
    logic [33:0] got, exp;

    always #5 clk = ~clk;

    port_req_ctrl #(.PORTNUM(16), .PORT_ID(0), .DATA_WIDTH(32), .DEPTH(8)) u0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_wr_vld(wr_vld[0]), .i_wr_sop(wr_sop[0]),
        .i_wr_eop(wr_eop[0]), .i_wr_data(wr_data[0]), .o_wr_ready(wr_ready[0]),
        .o_req(req[0]), .i_port_ready(1'b1), .i_resp(resp[0]), .i_nresp(nresp[0]),
        .o_data(data[0]), .o_data_vld(data_vld[0]), .o_eop(eop[0]), .o_trunc(trunc[0]),
        .o_lost_cnt(lost[0]));

    port_req_ctrl #(.PORTNUM(16), .PORT_ID(3), .DATA_WIDTH(32), .DEPTH(8)) u3 (
        .i_clk(clk), .i_rst_n(rst_n), .i_wr_vld(wr_vld[1]), .i_wr_sop(wr_sop[1]),
        .i_wr_eop(wr_eop[1]), .i_wr_data(wr_data[1]), .o_wr_ready(wr_ready[1]),
        .o_req(req[1]), .i_port_ready(1'b1), .i_resp(resp[1]), .i_nresp(nresp[1]),
        .o_data(data[1]), .o_data_vld(data_vld[1]), .o_eop(eop[1]), .o_trunc(trunc[1]),
        .o_lost_cnt(lost[1]));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input int p, input logic s, input logic e, input logic [31:0] d);
        wr_vld[p] = 1'b1;
        wr_sop[p] = s;
        wr_eop[p] = e;
        wr_data[p] = d;
        step();
        wr_vld[p] = 1'b0;
        wr_sop[p] = 1'b0;
        wr_eop[p] = 1'b0;
    endtask

    task automatic grant(input int p);
        resp[p] = 1'b1;
        step();
        resp[p] = 1'b0;
    endtask

    task automatic test_reset();
        step();
        step();
        total++; if (wr_ready !== 2'b00) $display("FAIL reset_wr_ready got %b want 00", wr_ready); else pass++;
        total++; if ({req, data_vld, eop, trunc} !== 8'h00) $display("FAIL reset_ctrl got %h want 00", {req, data_vld, eop, trunc}); else pass++;
        total++; if (data[0] !== 32'h0 || lost[0] !== 8'h0) $display("FAIL reset_data got %h/%h want 0/0", data[0], lost[0]); else pass++;
        rst_n = 1'b1;
        #1;
        total++; if (wr_ready !== 2'b11) $display("FAIL reset_release_ready got %b want 11", wr_ready); else pass++;
        nresp[0] = 1'b1;
        step();
        nresp[0] = 1'b0;
        total++; if (lost[0] !== 8'h0) $display("FAIL idle_nresp_ignored got %0d want 0", lost[0]); else pass++;
    endtask

    task automatic test_basic();
        for (int i = 0; i < 4; i++) put(0, i == 0, i == 3, 32'hA0 + i);
        total++; if (req[0] !== 1'b1) $display("FAIL basic_req got %b want 1", req[0]); else pass++;
        total++; if (wr_ready[0] !== 1'b0) $display("FAIL basic_ready_low got %b want 0", wr_ready[0]); else pass++;
        step();
        total++; if (req[0] !== 1'b1 || data_vld[0] !== 1'b0) $display("FAIL basic_req_hold got %b%b want 10", req[0], data_vld[0]); else pass++;
        grant(0);
        total++; if (req[0] !== 1'b0) $display("FAIL basic_req_drop got %b want 0", req[0]); else pass++;
        for (int i = 0; i < 4; i++) begin
            got = {data_vld[0], eop[0], data[0]};
            exp = {1'b1, i == 3, 32'hA0 + 32'(i)};
            total++; if (got !== exp) $display("FAIL basic_word%0d got %h want %h", i, got, exp); else pass++;
            step();
        end
        total++; if (data_vld[0] !== 1'b0 || wr_ready[0] !== 1'b1) $display("FAIL basic_end got vld=%b rdy=%b want 0 1", data_vld[0], wr_ready[0]); else pass++;
    endtask

    task automatic test_arbitration();
        for (int i = 0; i < 2; i++) begin
            wr_vld = 2'b11; wr_sop = {2{i == 0}}; wr_eop = {2{i == 1}};
            wr_data[0] = 32'hC0 + i; wr_data[1] = 32'hD0 + i;
            step();
        end
        wr_vld = '0; wr_sop = '0; wr_eop = '0;
        total++; if (req !== 2'b11) $display("FAIL arb_both_req got %b want 11", req); else pass++;
        resp = 2'b01; nresp = 2'b10;
        step();
        resp = '0; nresp = '0;
        total++; if (lost[1] !== 8'd1 || lost[0] !== 8'd0) $display("FAIL arb_lost got %0d/%0d want 0/1", lost[0], lost[1]); else pass++;
        total++; if (req !== 2'b10) $display("FAIL arb_req_after got %b want 10", req); else pass++;
        total++; if ({data_vld[0], eop[0], data[0]} !== {2'b10, 32'hC0}) $display("FAIL arb_p0_w0 got %h want 2000000c0", {data_vld[0], eop[0], data[0]}); else pass++;
        step();
        total++; if ({data_vld[0], eop[0], data[0]} !== {2'b11, 32'hC1}) $display("FAIL arb_p0_w1 got %h want 3000000c1", {data_vld[0], eop[0], data[0]}); else pass++;
        grant(1);
        total++; if ({data_vld[1], eop[1], data[1]} !== {2'b10, 32'hD0}) $display("FAIL arb_p3_w0 got %h want 2000000d0", {data_vld[1], eop[1], data[1]}); else pass++;
        total++; if (data_vld[0] !== 1'b0 || lost[1] !== 8'd1) $display("FAIL arb_p0_done got vld=%b lost=%0d want 0 1", data_vld[0], lost[1]); else pass++;
        step();
        total++; if ({data_vld[1], eop[1], data[1]} !== {2'b11, 32'hD1}) $display("FAIL arb_p3_w1 got %h want 3000000d1", {data_vld[1], eop[1], data[1]}); else pass++;
        step();
        total++; if (data_vld[1] !== 1'b0 || wr_ready[1] !== 1'b1) $display("FAIL arb_p3_end got vld=%b rdy=%b want 0 1", data_vld[1], wr_ready[1]); else pass++;
    endtask

    task automatic test_truncation();
        for (int i = 0; i < 10; i++) begin
            put(0, i == 0, i == 9, 32'hE0 + i);
            if (i == 7) begin
                total++; if (trunc[0] !== 1'b0) $display("FAIL trunc_early got %b want 0", trunc[0]); else pass++;
            end
            if (i == 8) begin
                total++; if (trunc[0] !== 1'b1 || wr_ready[0] !== 1'b1) $display("FAIL trunc_pulse got t=%b rdy=%b want 1 1", trunc[0], wr_ready[0]); else pass++;
            end
        end
        total++; if (trunc[0] !== 1'b0 || req[0] !== 1'b1) $display("FAIL trunc_once got t=%b req=%b want 0 1", trunc[0], req[0]); else pass++;
        grant(0);
        for (int i = 0; i < 8; i++) begin
            got = {data_vld[0], eop[0], data[0]};
            exp = {1'b1, i == 7, 32'hE0 + 32'(i)};
            total++; if (got !== exp) $display("FAIL trunc_word%0d got %h want %h", i, got, exp); else pass++;
            step();
        end
        total++; if (data_vld[0] !== 1'b0) $display("FAIL trunc_end got %b want 0", data_vld[0]); else pass++;
    endtask

    task automatic test_restart();
        for (int i = 0; i < 3; i++) put(0, i == 0, 1'b0, 32'hF0 + i);
        put(0, 1'b1, 1'b0, 32'hB0);
        put(0, 1'b0, 1'b1, 32'hB1);
        grant(0);
        total++; if ({data_vld[0], eop[0], data[0]} !== {2'b10, 32'hB0}) $display("FAIL restart_w0 got %h want 2000000b0", {data_vld[0], eop[0], data[0]}); else pass++;
        step();
        total++; if ({data_vld[0], eop[0], data[0]} !== {2'b11, 32'hB1}) $display("FAIL restart_w1 got %h want 3000000b1", {data_vld[0], eop[0], data[0]}); else pass++;
        step();
        total++; if (data_vld[0] !== 1'b0) $display("FAIL restart_end got %b want 0", data_vld[0]); else pass++;
    endtask

    task automatic test_back_to_back();
        put(0, 1'b1, 1'b1, 32'h55);
        total++; if (req[0] !== 1'b1) $display("FAIL single_req got %b want 1", req[0]); else pass++;
        grant(0);
        total++; if ({data_vld[0], eop[0], data[0]} !== {2'b11, 32'h55}) $display("FAIL single_word got %h want 300000055", {data_vld[0], eop[0], data[0]}); else pass++;
        step();
        total++; if (data_vld[0] !== 1'b0 || wr_ready[0] !== 1'b1) $display("FAIL single_end got vld=%b rdy=%b want 0 1", data_vld[0], wr_ready[0]); else pass++;
        put(0, 1'b1, 1'b1, 32'h66);
        total++; if (req[0] !== 1'b1) $display("FAIL b2b_req got %b want 1", req[0]); else pass++;
        grant(0);
        total++; if ({data_vld[0], eop[0], data[0]} !== {2'b11, 32'h66}) $display("FAIL b2b_word got %h want 300000066", {data_vld[0], eop[0], data[0]}); else pass++;
        step();
    endtask

    task automatic test_reset_mid_send();
        for (int i = 0; i < 4; i++) put(0, i == 0, i == 3, 32'h90 + i);
        grant(0);
        step();
        total++; if (data_vld[0] !== 1'b1) $display("FAIL midrst_sending got %b want 1", data_vld[0]); else pass++;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        #1;
        total++; if (data_vld[0] !== 1'b0 || req[0] !== 1'b0 || wr_ready[0] !== 1'b1) $display("FAIL midrst_ctrl got vld=%b req=%b rdy=%b want 0 0 1", data_vld[0], req[0], wr_ready[0]); else pass++;
        total++; if (lost[1] !== 8'd0 || data[0] !== 32'h0) $display("FAIL midrst_regs got lost=%0d data=%h want 0 0", lost[1], data[0]); else pass++;
        step();
        total++; if (data_vld[0] !== 1'b0 || eop[0] !== 1'b0) $display("FAIL midrst_quiet got vld=%b eop=%b want 0 0", data_vld[0], eop[0]); else pass++;
    endtask

    task automatic test_saturation();
        put(1, 1'b1, 1'b1, 32'h77);
        for (int i = 1; i <= 256; i++) begin
            nresp[1] = 1'b1;
            step();
            nresp[1] = 1'b0;
            if (i == 254) begin
                total++; if (lost[1] !== 8'd254) $display("FAIL sat_254 got %0d want 254", lost[1]); else pass++;
            end
        end
        total++; if (lost[1] !== 8'd255 || req[1] !== 1'b1) $display("FAIL sat_255 got lost=%0d req=%b want 255 1", lost[1], req[1]); else pass++;
        nresp[1] = 1'b1;
        resp[1] = 1'b1;
        step();
        nresp[1] = 1'b0;
        resp[1] = 1'b0;
        total++; if ({data_vld[1], eop[1], data[1]} !== {2'b11, 32'h77} || lost[1] !== 8'd255) $display("FAIL sat_grant got %h lost=%0d want 300000077 255", {data_vld[1], eop[1], data[1]}, lost[1]); else pass++;
        step();
    endtask

    initial begin
        wr_data[0] = '0;
        wr_data[1] = '0;
        test_reset();
        test_basic();
        test_arbitration();
        test_truncation();
        test_restart();
        test_back_to_back();
        test_reset_mid_send();
        test_saturation();
        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end
endmodule
